tlul_host_arbiter: RTL and testbench
====================================

TLUL_HOST_ARBITER -- requirements
Module: tlul_host_arbiter

Interface
REQ-001 Parameter AW, default 12: address width of requester and channel A address fields.
REQ-002 Parameter DW, default 32: data width of requester, channel A and channel D data fields.
REQ-003 Parameter TIMEOUT, default 255: channel D response timeout in cycles; used only when TLUL_ARB_TIMEOUT_EN is defined.
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 reqN_valid_i  in  1  requester N (N=0,1) has a transaction pending.
REQ-007 reqN_opcode_i / reqN_address_i / reqN_data_i  in  3/AW/DW  requester N payload.
REQ-008 reqN_ready_o  out  1  one-cycle pulse: requester N payload accepted.
REQ-009 rspN_valid_o  out  1  one-cycle pulse: response for requester N.
REQ-010 rspN_data_o / rspN_error_o  out  DW/1  response data and error flag for requester N.
REQ-011 a_valid_o, a_ready_i  out/in  1/1  channel A handshake.
REQ-012 a_opcode_o / a_address_o / a_data_o  out  3/AW/DW  channel A payload.
REQ-013 a_size_o / a_mask_o / a_source_o  out  2/4/1  size (fixed 2'b10), mask (fixed 4'hF), granted requester index.
REQ-014 d_valid_i, d_ready_o  in/out  1/1  channel D handshake.
REQ-015 d_data_i / d_error_i / d_source_i  in  DW/1/1  channel D response payload.

Function
REQ-016 FSM states: IDLE, A_SEND, D_WAIT; exactly one outstanding transaction at any time.
REQ-017 IDLE: if any reqN_valid_i = 1, the block selects one requester, pulses its reqN_ready_o, latches its payload and index into internal registers, and moves to A_SEND on the next edge.
REQ-018 Arbitration: round-robin; a 1-bit pointer names the preferred requester; if only one requester is valid, that requester wins regardless of the pointer.
REQ-019 The pointer updates to the non-granted index when the transaction completes (REQ-022/REQ-023).
REQ-020 A_SEND: a_valid_o = 1 with the latched payload held stable; the block moves to D_WAIT on the edge where a_ready_i = 1; a_valid_o = 0 in all other states.
REQ-021 Latency: payload accepted in cycle n; a_valid_o asserted in cycle n+1; minimum request-to-response time is 3 cycles.
REQ-022 D_WAIT: d_ready_o = 1; on d_valid_i = 1 with d_source_i equal to the latched index, the block pulses rsp{idx}_valid_o for one cycle with rsp{idx}_data_o = d_data_i and rsp{idx}_error_o = d_error_i, then returns to IDLE.
REQ-023 D_WAIT, d_valid_i = 1 with a mismatched d_source_i: the beat is consumed and dropped; the block stays in D_WAIT.
REQ-024 d_ready_o = 0 in IDLE and A_SEND.
REQ-025 reqN_valid_i changes during A_SEND or D_WAIT have no effect on latched data.
REQ-026 rspN_data_o and rspN_error_o are registered and hold their last values between pulses.
REQ-027 A new grant may occur in the IDLE cycle immediately following completion.

Reset
REQ-028 While rst_ni = 0, the block forces: FSM to IDLE, pointer to 0, counter to 0, latched payload to 0, and all outputs to 0 except a_size_o = 2'b10 and a_mask_o = 4'hF.
REQ-029 Reset mid-transaction abandons the transaction with no response pulse; the first grant after reset release goes to requester 0 when both requesters are valid.

Configuration
REQ-030 When TLUL_ARB_TIMEOUT_EN is defined, an 8-bit counter clears on entry to D_WAIT and increments each cycle in D_WAIT; when it reaches TIMEOUT with no matching response, the block pulses rsp{idx}_valid_o with data 0 and error 1, updates the pointer, and returns to IDLE.
REQ-031 When TLUL_ARB_TIMEOUT_EN is undefined, no counter exists and D_WAIT waits indefinitely.

Verification
REQ-032 Only req0 is valid with opcode 4, address 0x010 and data 0xDEADBEEF; a_ready_i = 1; d_valid_i arrives 2 cycles later with source 0 and data 0x12345678 -> the bench sees a_valid_o with that payload and source 0, one rsp0_valid_o pulse with data 0x12345678, and no rsp1 pulse.
REQ-033 Both requesters are held valid for 4 transactions -> grants occur in order 0,1,0,1.
REQ-034 a_ready_i is held at 0 for 5 cycles in A_SEND -> a_valid_o stays 1 with a stable payload, and D_WAIT is entered only after a_ready_i = 1.
REQ-035 In D_WAIT with index 1, a beat arrives with d_source_i = 0, followed by a beat with d_source_i = 1 -> the first beat is dropped and only rsp1_valid_o pulses.
REQ-036 rst_ni is pulled to 0 during D_WAIT -> all outputs return to reset values immediately, and no response pulse occurs after release.
REQ-037 With TLUL_ARB_TIMEOUT_EN defined and no channel D response -> rspN_valid_o pulses with error = 1 and data = 0 after TIMEOUT cycles, and the state returns to IDLE.

Source files
------------

// File: rtl/tlul_host_arbiter.sv
`default_nettype none
// =============================================================================
// tlul_host_arbiter -- two-requester round-robin TL-UL host arbiter, one
// outstanding transaction. Optional D-channel timeout: TLUL_ARB_TIMEOUT_EN.
// Revision: 1.0
// =============================================================================
module tlul_host_arbiter #(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic          req0_valid_i,
  input  logic [2:0]    req0_opcode_i,
  input  logic [AW-1:0] req0_address_i,
  input  logic [DW-1:0] req0_data_i,
  output logic          req0_ready_o,

  input  logic          req1_valid_i,
  input  logic [2:0]    req1_opcode_i,
  input  logic [AW-1:0] req1_address_i,
  input  logic [DW-1:0] req1_data_i,
  output logic          req1_ready_o,

  output logic          rsp0_valid_o,
  output logic [DW-1:0] rsp0_data_o,
  output logic          rsp0_error_o,

  output logic          rsp1_valid_o,
  output logic [DW-1:0] rsp1_data_o,
  output logic          rsp1_error_o,

  output logic          a_valid_o,
  input  logic          a_ready_i,
  output logic [2:0]    a_opcode_o,
  output logic [AW-1:0] a_address_o,
  output logic [DW-1:0] a_data_o,
  output logic [1:0]    a_size_o,
  output logic [3:0]    a_mask_o,
  output logic          a_source_o,

  input  logic          d_valid_i,
  output logic          d_ready_o,
  input  logic [DW-1:0] d_data_i,
  input  logic          d_error_i,
  input  logic          d_source_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_SEND = 2'd1,
    D_WAIT = 2'd2
  } state_e;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("TIMEOUT must fit the 8-bit response counter");
  end

  state_e        state_q;
  logic          ptr_q;
  logic          idx_q;
  logic [2:0]    opcode_q;
  logic [AW-1:0] address_q;
  logic [DW-1:0] data_q;
  logic          rsp0_valid_q;
  logic          rsp1_valid_q;
  logic [DW-1:0] rsp0_data_q;
  logic [DW-1:0] rsp1_data_q;
  logic          rsp0_error_q;
  logic          rsp1_error_q;

  logic          any_req;
  logic          grant_idx;
  logic          d_match;
  logic          timeout;
  logic          done;
  logic [DW-1:0] done_data;
  logic          done_error;

  assign any_req   = req0_valid_i | req1_valid_i;
  // The pointer only matters when both requesters compete.
  assign grant_idx = (req0_valid_i & req1_valid_i) ? ptr_q : req1_valid_i;
  assign d_match   = d_valid_i & (d_source_i == idx_q);

`ifdef TLUL_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] cnt_q;
  assign timeout = (cnt_q == TIMEOUT_CNT);
`else
  assign timeout = 1'b0;
`endif

  // A matching beat in the same cycle as expiry wins over the timeout.
  assign done       = (state_q == D_WAIT) & (d_match | timeout);
  assign done_data  = d_match ? d_data_i  : '0;
  assign done_error = d_match ? d_error_i : 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      idx_q        <= 1'b0;
      opcode_q     <= '0;
      address_q    <= '0;
      data_q       <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      rsp0_error_q <= 1'b0;
      rsp1_error_q <= 1'b0;
`ifdef TLUL_ARB_TIMEOUT_EN
      cnt_q        <= 8'd0;
`endif
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            idx_q     <= grant_idx;
            opcode_q  <= grant_idx ? req1_opcode_i  : req0_opcode_i;
            address_q <= grant_idx ? req1_address_i : req0_address_i;
            data_q    <= grant_idx ? req1_data_i    : req0_data_i;
            state_q   <= A_SEND;
          end
        end
        A_SEND: begin
          if (a_ready_i) begin
            state_q <= D_WAIT;
`ifdef TLUL_ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
          end
        end
        D_WAIT: begin
          if (done) begin
            if (idx_q) begin
              rsp1_valid_q <= 1'b1;
              rsp1_data_q  <= done_data;
              rsp1_error_q <= done_error;
            end else begin
              rsp0_valid_q <= 1'b1;
              rsp0_data_q  <= done_data;
              rsp0_error_q <= done_error;
            end
            ptr_q   <= ~idx_q;
            state_q <= IDLE;
          end else begin
`ifdef TLUL_ARB_TIMEOUT_EN
            cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Acceptance must fall in the grant cycle itself, so ready is decoded, not registered.
  assign req0_ready_o = rst_ni & (state_q == IDLE) & any_req & ~grant_idx;
  assign req1_ready_o = rst_ni & (state_q == IDLE) & any_req &  grant_idx;

  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp0_data_o  = rsp0_data_q;
  assign rsp0_error_o = rsp0_error_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp1_data_o  = rsp1_data_q;
  assign rsp1_error_o = rsp1_error_q;

  assign a_valid_o   = (state_q == A_SEND);
  assign a_opcode_o  = opcode_q;
  assign a_address_o = address_q;
  assign a_data_o    = data_q;
  assign a_size_o    = 2'b10;
  assign a_mask_o    = 4'hF;
  assign a_source_o  = idx_q;

  assign d_ready_o   = (state_q == D_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_tlul_host_arbiter.sv
`default_nettype none
// Testbench for tlul_host_arbiter: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_tlul_host_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          req0_valid_i, req1_valid_i;
  logic [2:0]    req0_opcode_i, req1_opcode_i;
  logic [AW-1:0] req0_address_i, req1_address_i;
  logic [DW-1:0] req0_data_i, req1_data_i;
  logic          req0_ready_o, req1_ready_o;
  logic          rsp0_valid_o, rsp1_valid_o;
  logic [DW-1:0] rsp0_data_o, rsp1_data_o;
  logic          rsp0_error_o, rsp1_error_o;
  logic          a_valid_o, a_ready_i;
  logic [2:0]    a_opcode_o;
  logic [AW-1:0] a_address_o;
  logic [DW-1:0] a_data_o;
  logic [1:0]    a_size_o;
  logic [3:0]    a_mask_o;
  logic          a_source_o;
  logic          d_valid_i, d_ready_o;
  logic [DW-1:0] d_data_i;
  logic          d_error_i, d_source_i;

  always #5 clk = ~clk;

  tlul_host_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req0_valid_i(req0_valid_i), .req0_opcode_i(req0_opcode_i),
    .req0_address_i(req0_address_i), .req0_data_i(req0_data_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_opcode_i(req1_opcode_i),
    .req1_address_i(req1_address_i), .req1_data_i(req1_data_i), .req1_ready_o(req1_ready_o),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_data_o(rsp0_data_o), .rsp0_error_o(rsp0_error_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_data_o(rsp1_data_o), .rsp1_error_o(rsp1_error_o),
    .a_valid_o(a_valid_o), .a_ready_i(a_ready_i), .a_opcode_o(a_opcode_o),
    .a_address_o(a_address_o), .a_data_o(a_data_o), .a_size_o(a_size_o),
    .a_mask_o(a_mask_o), .a_source_o(a_source_o),
    .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_data_i(d_data_i),
    .d_error_i(d_error_i), .d_source_i(d_source_i)
  );

  int n_tests = 0;
  int n_fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding transaction record.
  bit          m_have, m_sent, m_idx, m_ptr;
  bit [2:0]    m_op;
  bit [AW-1:0] m_addr;
  bit [DW-1:0] m_data;
  bit          m_pulse [2];
  bit [DW-1:0] m_rdata [2];
  bit          m_rerr  [2];
  int          m_wait;

  bit grants[$];
  int n_rsp0 = 0;
  int n_rsp1 = 0;

  task automatic model_reset();
    m_have = 0; m_sent = 0; m_idx = 0; m_ptr = 0;
    m_op = '0; m_addr = '0; m_data = '0; m_wait = 0;
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 0; m_rdata[i] = '0; m_rerr[i] = 0;
    end
  endtask

  task automatic finish_txn(input bit [DW-1:0] data, input bit err);
    m_pulse[m_idx] = 1;
    m_rdata[m_idx] = data;
    m_rerr[m_idx]  = err;
    m_have = 0;
    m_ptr  = !m_idx;
  endtask

  task automatic model_step(input bit anyv, input bit g);
    m_pulse[0] = 0;
    m_pulse[1] = 0;
    if (!m_have && anyv) begin
      m_have = 1; m_sent = 0; m_idx = g;
      m_op   = g ? req1_opcode_i  : req0_opcode_i;
      m_addr = g ? req1_address_i : req0_address_i;
      m_data = g ? req1_data_i    : req0_data_i;
    end else if (m_have && !m_sent) begin
      if (a_ready_i) begin
        m_sent = 1;
        m_wait = 0;
      end
    end else if (m_have) begin
      if (d_valid_i && d_source_i == m_idx) finish_txn(d_data_i, d_error_i);
`ifdef TLUL_ARB_TIMEOUT_EN
      else if (m_wait == TO) finish_txn('0, 1'b1);
`endif
      else m_wait++;
    end
  endtask

  always @(negedge clk) begin
    bit anyv, g;
    if (!rst_ni) model_reset();
    anyv = req0_valid_i || req1_valid_i;
    g    = (req0_valid_i && req1_valid_i) ? m_ptr : req1_valid_i;
    chk("req0_ready", req0_ready_o, rst_ni && !m_have && anyv && !g);
    chk("req1_ready", req1_ready_o, rst_ni && !m_have && anyv && g);
    chk("a_valid", a_valid_o, m_have && !m_sent);
    chk("d_ready", d_ready_o, m_have && m_sent);
    chk("a_opcode", a_opcode_o, m_op);
    chk("a_address", a_address_o, m_addr);
    chk("a_data", a_data_o, m_data);
    chk("a_source", a_source_o, m_idx);
    chk("a_size", a_size_o, 2'b10);
    chk("a_mask", a_mask_o, 4'hF);
    chk("rsp0_valid", rsp0_valid_o, m_pulse[0]);
    chk("rsp1_valid", rsp1_valid_o, m_pulse[1]);
    chk("rsp0_data", rsp0_data_o, m_rdata[0]);
    chk("rsp1_data", rsp1_data_o, m_rdata[1]);
    chk("rsp0_error", rsp0_error_o, m_rerr[0]);
    chk("rsp1_error", rsp1_error_o, m_rerr[1]);
    if (req0_ready_o) grants.push_back(1'b0);
    if (req1_ready_o) grants.push_back(1'b1);
    if (rsp0_valid_o) n_rsp0++;
    if (rsp1_valid_o) n_rsp1++;
    if (rst_ni) model_step(anyv, g);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_dready();
    int n = 0;
    while (!d_ready_o && n < 40) begin
      tick();
      n++;
    end
    chk("wait_d_ready_bound", d_ready_o, 1'b1);
  endtask

  task automatic respond(input bit src, input bit [DW-1:0] data, input bit err);
    d_valid_i = 1; d_source_i = src; d_data_i = data; d_error_i = err;
    tick();
    d_valid_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, k;
    bit src;
    rst_ni = 1;
    req0_valid_i = 0; req0_opcode_i = '0; req0_address_i = '0; req0_data_i = '0;
    req1_valid_i = 0; req1_opcode_i = '0; req1_address_i = '0; req1_data_i = '0;
    a_ready_i = 0; d_valid_i = 0; d_data_i = '0; d_error_i = 0; d_source_i = 0;
    #1 rst_ni = 0;
    tick(3);
    chk("rst_a_valid", a_valid_o, 1'b0);
    chk("rst_d_ready", d_ready_o, 1'b0);
    chk("rst_a_size", a_size_o, 2'b10);
    chk("rst_a_mask", a_mask_o, 4'hF);
    rst_ni = 1;

    // Single requester transaction with minimum latency.
    req0_valid_i = 1; req0_opcode_i = 3'd4; req0_address_i = 12'h010; req0_data_i = 32'hDEADBEEF;
    a_ready_i = 1;
    #1;
    chk("t1_ready0", req0_ready_o, 1'b1);
    tick();
    req0_valid_i = 0;
    chk("t1_a_valid", a_valid_o, 1'b1);
    chk("t1_a_opcode", a_opcode_o, 3'd4);
    chk("t1_a_address", a_address_o, 12'h010);
    chk("t1_a_data", a_data_o, 32'hDEADBEEF);
    chk("t1_a_source", a_source_o, 1'b0);
    tick();
    chk("t1_d_ready", d_ready_o, 1'b1);
    respond(1'b0, 32'h12345678, 1'b0);
    chk("t1_rsp0_valid", rsp0_valid_o, 1'b1);
    chk("t1_rsp0_data", rsp0_data_o, 32'h12345678);
    chk("t1_rsp1_valid", rsp1_valid_o, 1'b0);
    tick(3);
    chk("t1_rsp0_count", n_rsp0, 1);
    chk("t1_rsp1_count", n_rsp1, 0);

    // Reset, then both requesters compete for four transactions.
    rst_ni = 0;
    tick(2);
    rst_ni = 1;
    grants.delete();
    req0_opcode_i = 3'd0; req0_address_i = 12'h100; req0_data_i = 32'hA0A0A0A0;
    req1_opcode_i = 3'd1; req1_address_i = 12'h200; req1_data_i = 32'hB1B1B1B1;
    req0_valid_i = 1; req1_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      wait_dready();
      src = a_source_o;
      if (i == 3) begin
        req0_valid_i = 0;
        req1_valid_i = 0;
      end
      respond(src, 32'h1000 + i, i == 3);
    end
    tick(3);
    chk("t2_grant_count", grants.size(), 4);
    chk("t2_grant0", grants[0], 1'b0);
    chk("t2_grant1", grants[1], 1'b1);
    chk("t2_grant2", grants[2], 1'b0);
    chk("t2_grant3", grants[3], 1'b1);
    chk("t2_rsp0_data", rsp0_data_o, 32'h1002);
    chk("t2_rsp1_data", rsp1_data_o, 32'h1003);
    chk("t2_rsp0_error", rsp0_error_o, 1'b0);
    chk("t2_rsp1_error", rsp1_error_o, 1'b1);

    // Channel A back-pressure; requester payload changes must not leak.
    req1_valid_i = 1; req1_opcode_i = 3'd5; req1_address_i = 12'h3A5; req1_data_i = 32'hCAFEF00D;
    a_ready_i = 0;
    tick();
    req1_valid_i = 0; req1_opcode_i = 3'd7; req1_address_i = 12'h000; req1_data_i = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      chk("t3_a_valid_held", a_valid_o, 1'b1);
      chk("t3_a_data_stable", a_data_o, 32'hCAFEF00D);
      chk("t3_a_address_stable", a_address_o, 12'h3A5);
      chk("t3_no_d_ready", d_ready_o, 1'b0);
      tick();
    end
    chk("t3_a_valid_before_ready", a_valid_o, 1'b1);
    a_ready_i = 1;
    tick();
    a_ready_i = 0;
    chk("t3_d_wait_entered", d_ready_o, 1'b1);
    chk("t3_a_valid_dropped", a_valid_o, 1'b0);

    // Mismatched source is dropped; only the matching beat answers.
    respond(1'b0, 32'hBAD0BAD0, 1'b1);
    chk("t4_still_waiting", d_ready_o, 1'b1);
    chk("t4_no_rsp0", rsp0_valid_o, 1'b0);
    chk("t4_no_rsp1_yet", rsp1_valid_o, 1'b0);
    respond(1'b1, 32'h600D600D, 1'b0);
    chk("t4_rsp1_valid", rsp1_valid_o, 1'b1);
    chk("t4_rsp1_data", rsp1_data_o, 32'h600D600D);
    chk("t4_rsp1_error", rsp1_error_o, 1'b0);
    chk("t4_rsp0_data_held", rsp0_data_o, 32'h1002);
    tick(2);

    // Reset during D_WAIT abandons the transaction.
    req0_valid_i = 1; req0_opcode_i = 3'd2; req0_address_i = 12'h0FF; req0_data_i = 32'h55AA55AA;
    a_ready_i = 1;
    tick();
    req0_valid_i = 0;
    tick();
    chk("t5_in_d_wait", d_ready_o, 1'b1);
    s0 = n_rsp0;
    s1 = n_rsp1;
    rst_ni = 0;
    #1;
    chk("t5_rst_d_ready", d_ready_o, 1'b0);
    chk("t5_rst_a_valid", a_valid_o, 1'b0);
    chk("t5_rst_a_address", a_address_o, 12'h000);
    chk("t5_rst_a_data", a_data_o, 32'h0);
    chk("t5_rst_rsp1_data", rsp1_data_o, 32'h0);
    chk("t5_rst_a_size", a_size_o, 2'b10);
    chk("t5_rst_a_mask", a_mask_o, 4'hF);
    tick(2);
    rst_ni = 1;
    respond(1'b0, 32'h77777777, 1'b0);
    tick(4);
    chk("t5_no_rsp0_after", n_rsp0, s0);
    chk("t5_no_rsp1_after", n_rsp1, s1);
    chk("t5_rsp0_data_clear", rsp0_data_o, 32'h0);

`ifdef TLUL_ARB_TIMEOUT_EN
    // No response at all: timeout answers with error.
    req1_valid_i = 1; req1_data_i = 32'h00001234;
    a_ready_i = 1;
    tick();
    req1_valid_i = 0;
    k = 0;
    while (!rsp1_valid_o && k < TO + 20) begin
      tick();
      k++;
    end
    chk("t6_timeout_latency", k, TO + 2);
    chk("t6_rsp1_error", rsp1_error_o, 1'b1);
    chk("t6_rsp1_data", rsp1_data_o, 32'h0);
    tick();
    chk("t6_idle_a_valid", a_valid_o, 1'b0);
    chk("t6_idle_d_ready", d_ready_o, 1'b0);
`else
    k = 0;
`endif

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
